// File: rtl/scan_sel_gen.sv
// Registered 8-channel scan sequencer driving a 3-to-8 decoder's select/enable.
// Optional blank cycle before each channel re-entry: define SCAN_BLANK_EN.
module scan_sel_gen #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               wrap
);

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_BLANK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DRIVE} state_t;
`endif

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [2:0]         sel_d;
    logic               en_d, busy_d, wrap_d;

    logic [2:0] first_ch, next_ch;
    logic       first_found, next_found;
    logic [2:0] idx;

    // Next set bit strictly above sel, wrapping; the 8th probe lands back on sel itself.
    always_comb begin
        first_ch    = '0;
        first_found = 1'b0;
        next_ch     = sel;
        next_found  = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!first_found && mask[i[2:0]]) begin
                first_found = 1'b1;
                first_ch    = i[2:0];
            end
        end
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = sel + i[2:0];
            if (!next_found && mask[idx]) begin
                next_found = 1'b1;
                next_ch    = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel;
        en_d    = en;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && first_found) begin
                    state_d = S_DRIVE;
                    sel_d   = first_ch;
                    cnt_d   = dwell;
                    en_d    = 1'b1;
                end
            end
            S_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
                end else if (!next_found) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                end else begin
                    sel_d  = next_ch;
                    cnt_d  = dwell;
                    wrap_d = (next_ch <= sel);
`ifdef SCAN_BLANK_EN
                    state_d = S_BLANK;
                    en_d    = 1'b0;
`endif
                end
            end
`ifdef SCAN_BLANK_EN
            S_BLANK: begin
                state_d = S_DRIVE;
                en_d    = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
        if (stop) begin
            state_d = S_IDLE;
            sel_d   = sel;
            en_d    = 1'b0;
            wrap_d  = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel     <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel     <= sel_d;
            en      <= en_d;
            busy    <= busy_d;
            wrap    <= wrap_d;
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Randomized bench for scan_sel_gen against a cycle-level behavioural model of the scan rules.
module tb_scan_sel_gen;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst, start, stop;
    logic [DW-1:0] dwell;
    logic [7:0]    mask;
    logic [2:0]    sel;
    logic          en, busy, wrap;

    int n_checks = 0;
    int n_errors = 0;

    int m_sel, m_left;
    bit m_en, m_busy, m_wrap, m_blank;

    scan_sel_gen #(.DWELL_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .dwell (dwell),
        .mask  (mask),
        .sel   (sel),
        .en    (en),
        .busy  (busy),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task model_reset();
        m_sel = 0; m_left = 0; m_en = 0; m_busy = 0; m_wrap = 0; m_blank = 0;
    endtask

    // One clock edge of the scan rules, using the inputs as presented at that edge.
    task model_update();
        int nxt;
        bit hit;
        if (stop) begin
            m_busy = 0; m_en = 0; m_wrap = 0; m_blank = 0;
        end else if (!m_busy) begin
            m_wrap = 0;
            if (start && mask != 0) begin
                for (int k = 7; k >= 0; k--) if (mask[k]) m_sel = k;
                m_left = int'(dwell);
                m_busy = 1;
                m_en   = 1;
            end
        end else if (m_blank) begin
            m_blank = 0; m_en = 1; m_wrap = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_wrap = 0;
        end else if (mask == 0) begin
            m_busy = 0; m_en = 0; m_wrap = 0;
        end else begin
            hit = 0;
            nxt = m_sel;
            for (int k = 1; k <= 8; k++)
                if (!hit && mask[(m_sel + k) % 8]) begin hit = 1; nxt = (m_sel + k) % 8; end
            m_wrap = (nxt <= m_sel);
            m_sel  = nxt;
            m_left = int'(dwell);
`ifdef SCAN_BLANK_EN
            m_blank = 1;
            m_en    = 0;
`endif
        end
    endtask

    task step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".sel"},  32'(sel),  32'(m_sel));
        check({tag, ".en"},   32'(en),   32'(m_en));
        check({tag, ".busy"}, 32'(busy), 32'(m_busy));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Asynchronous reset applied between edges; outputs must clear without a clock.
    task async_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, ".sel"},  32'(sel),  0);
        check({tag, ".en"},   32'(en),   0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".wrap"}, 32'(wrap), 0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    initial begin
        int exp_seq[6];
        exp_seq = '{2, 5, 7, 2, 5, 7};
        rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = '0; mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.sel",  32'(sel),  0);
        check("reset.en",   32'(en),   0);
        check("reset.busy", 32'(busy), 0);
        check("reset.wrap", 32'(wrap), 0);
        rst = 1'b0;
        step("idle");

        // Full mask, dwell 2
        mask = 8'hFF; dwell = 8'd2; start = 1'b1;
        repeat (30) step("full");
        stop = 1'b1; step("full_stop");

        // Sparse mask, dwell 0
        mask = 8'b1010_0100; dwell = 8'd0; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step("sparse");
`ifndef SCAN_BLANK_EN
            check("sparse_seq", 32'(sel), 32'(exp_seq[k]));
`endif
        end
        repeat (6) step("sparse");
        stop = 1'b1; step("sparse_stop");

        // Single channel re-enters itself
        mask = 8'b0001_0000; dwell = 8'd3; start = 1'b1;
        repeat (20) step("single");
        check("single_sel", 32'(sel), 4);
        stop = 1'b1; step("single_stop");

        // Stop mid-dwell on channel 3
        mask = 8'b0000_1000; dwell = 8'd5; start = 1'b1;
        step("stop3"); step("stop3");
        stop = 1'b1; step("stop3");
        check("stop3_sel",  32'(sel),  3);
        check("stop3_en",   32'(en),   0);
        check("stop3_busy", 32'(busy), 0);

        // start and stop together, start with empty mask
        mask = 8'hFF; start = 1'b1; stop = 1'b1; step("startstop");
        check("startstop_busy", 32'(busy), 0);
        mask = 8'h00; start = 1'b1; step("mask0");
        check("mask0_busy", 32'(busy), 0);
        step("mask0");

        // Clearing the mask mid-dwell finishes the channel, then idles
        mask = 8'hFF; dwell = 8'd3; start = 1'b1; step("mclr");
        mask = 8'h00;
        repeat (3) step("mclr");
        check("mclr_busy_hold", 32'(busy), 1);
        step("mclr");
        check("mclr_busy", 32'(busy), 0);
        check("mclr_sel",  32'(sel),  0);

        // Reset during a scan (mid-blank when blanking is compiled in)
        mask = 8'hFF; dwell = 8'd1; start = 1'b1;
        repeat (3) step("blank");
        async_reset("async_rst");
        step("post_rst");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0:       mask = 8'h00;
                    1:       mask = 8'(1 << $urandom_range(7));
                    default: mask = 8'($urandom);
                endcase
            end
            if ($urandom_range(7) == 0) dwell = 8'($urandom_range(3));
            start = ($urandom_range(7) == 0);
            stop  = ($urandom_range(39) == 0);
            if ($urandom_range(499) == 0) begin
                start = 1'b0; stop = 1'b0;
                async_reset("rand_rst");
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
